dram_port_arbiter: RTL and testbench
====================================

// Module: dram_port_arbiter
// PURPOSE
//  Shares the single-port data RAM between two requesters: port 0 = CPU load/store path, port 1 = program/debug loader.
//  Sits between the requesters and dram; owns address, write_data, read_not_write and cs to the RAM.
//  Sequences each access as a fixed-length transaction and returns read data with a one-cycle ack pulse.
// PARAMETERS
//  DATA_BUS_WIDTH     24  width of RAM data and requester wdata/rdata
//  ADDRESS_BUS_WIDTH  11  width of RAM address and requester addr
//  MEM_LATENCY         1  cycles cs is held per access (1..15); read data sampled on last cycle
// PORTS
//  clk             in   1    system clock, rising-edge
//  reset           in   1    asynchronous, active-low reset
//  req0/req1       in   1    requester N wants an access; held high until ackN
//  rnw0/rnw1       in   1    1 = read, 0 = write; stable while reqN high
//  addr0/addr1     in   AW   word address; stable while reqN high
//  wdata0/wdata1   in   DW   store data; stable while reqN high
//  ack0/ack1       out  1    one-cycle pulse: transaction N complete
//  rdata           out  DW   read result, valid only in the cycle ackN is high
//  mem_address     out  AW   to dram address
//  mem_write_data  out  DW   to dram write_data
//  mem_read_not_write out 1  to dram read_not_write
//  mem_cs          out  1    to dram cs
//  mem_read_data   in   DW   from dram read_data
//  busy            out  1    high in ACCESS and RESP states
// BEHAVIOUR
//  Reset (reset low, async): state=IDLE, last_grant=1, all outputs 0 except mem_read_not_write=1.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: if any reqN, pick winner, register its addr/wdata/rnw into mem_* regs, load cnt=MEM_LATENCY-1, go ACCESS.
//   ACCESS: mem_cs=1; cnt decrements each cycle; on cnt==0 capture mem_read_data into rdata (reads only), go RESP.
//   RESP: mem_cs=0, ack<winner>=1 for exactly this cycle, busy=1; next state IDLE.
//  Latency: req sampled in IDLE at edge T -> mem_cs high T+1..T+MEM_LATENCY -> ack high cycle T+MEM_LATENCY+1.
//  Min issue interval: MEM_LATENCY+2 cycles; a held req (new addr) is re-sampled in the IDLE after RESP.
//  Arbitration: only one req -> that port. Both -> port != last_grant (round-robin); last_grant updated on grant.
//  Grant is locked for whole transaction; changes on reqN or addrN mid-transaction are ignored.
//  reqN dropped mid-transaction: access still completes and ackN still pulses (no abort).
//  Writes: rdata holds its previous value; mem_write_data = winner's wdata throughout ACCESS.
//  mem_address/mem_write_data/mem_read_not_write hold last values in IDLE/RESP; mem_read_not_write returns to 1 in IDLE.
//  ack0 and ack1 never high in the same cycle; mem_cs never high outside ACCESS.
//  Reset mid-ACCESS: mem_cs drops immediately (async); no ack issued for the aborted transaction.
// CONFIGURATION
//  DRAM_ARB_FIXED_PRIO_EN defined: port 0 (CPU) always wins when both request; last_grant unused.
//  Not defined: round-robin as above.
// TESTING
//  reset low then high, no reqs -> all outputs 0, mem_read_not_write=1, busy=0, state IDLE.
//  MEM_LATENCY=1; req0 read addr 11'd5, RAM word5=24'h00ABCD -> mem_cs high 1 cycle, ack0 + rdata=24'h00ABCD 2 cycles after sample.
//  req1 write addr 11'd1023 wdata 24'h123456 -> mem_cs=1, mem_read_not_write=0, ack1 pulse; re-read via port 0 returns 24'h123456.
//  req0 and req1 held high continuously -> grants alternate 0,1,0,1 (fixed-prio build: 0,0,0,0; port 1 starved).
//  MEM_LATENCY=3; req0 read -> mem_cs high exactly 3 cycles, ack0 in 4th cycle after sample; busy high 4 cycles.
//  reset asserted during ACCESS -> mem_cs=0 same cycle, no ack0/ack1, next req after release served normally.

Source files
------------

// File: rtl/dram_port_arbiter.sv
// Two-port arbiter in front of the single-port data RAM (port 0 = CPU, port 1 = loader).
// Define DRAM_ARB_FIXED_PRIO_EN for fixed CPU priority instead of round-robin.
module dram_port_arbiter #(
  parameter int DATA_BUS_WIDTH    = 24,
  parameter int ADDRESS_BUS_WIDTH = 11,
  parameter int MEM_LATENCY       = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req0,
  input  logic                         req1,
  input  logic                         rnw0,
  input  logic                         rnw1,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr0,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr1,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata0,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata1,
  output logic                         ack0,
  output logic                         ack1,
  output logic [DATA_BUS_WIDTH-1:0]    rdata,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_address,
  output logic [DATA_BUS_WIDTH-1:0]    mem_write_data,
  output logic                         mem_read_not_write,
  output logic                         mem_cs,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_read_data,
  output logic                         busy
);

  localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic       winner;
  logic       pick;

`ifdef DRAM_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = ~req0;
  end
`else
  logic last_grant;

  always_comb begin
    pick = (req0 & req1) ? ~last_grant : req1;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state              <= IDLE;
      cnt                <= '0;
      winner             <= 1'b0;
      ack0               <= 1'b0;
      ack1               <= 1'b0;
      rdata              <= '0;
      mem_address        <= '0;
      mem_write_data     <= '0;
      mem_read_not_write <= 1'b1;
      mem_cs             <= 1'b0;
      busy               <= 1'b0;
`ifndef DRAM_ARB_FIXED_PRIO_EN
      last_grant         <= 1'b1;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req0 | req1) begin
            winner <= pick;
`ifndef DRAM_ARB_FIXED_PRIO_EN
            last_grant <= pick;
`endif
            mem_address        <= pick ? addr1 : addr0;
            mem_write_data     <= pick ? wdata1 : wdata0;
            mem_read_not_write <= pick ? rnw1 : rnw0;
            mem_cs             <= 1'b1;
            busy               <= 1'b1;
            cnt                <= CNT_INIT;
            state              <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            mem_cs <= 1'b0;
            if (mem_read_not_write) begin
              rdata <= mem_read_data;
            end
            ack0  <= ~winner;
            ack1  <= winner;
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          busy               <= 1'b0;
          mem_read_not_write <= 1'b1;
          state              <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter: LAT=1 instance with RAM model,
// plus a LAT=3 instance for multi-cycle access timing.
module tb_dram_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // instance a: MEM_LATENCY=1
  logic        req0, req1, rnw0, rnw1;
  logic [10:0] addr0, addr1;
  logic [23:0] wdata0, wdata1;
  logic        ack0, ack1, mem_rnw, mem_cs, busy;
  logic [23:0] rdata, mem_wdata, mem_rdata;
  logic [10:0] mem_addr;
  logic [23:0] ram [0:2047];

  dram_port_arbiter #(
    .DATA_BUS_WIDTH(24), .ADDRESS_BUS_WIDTH(11), .MEM_LATENCY(1)
  ) u_a (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .rnw0(rnw0), .rnw1(rnw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata),
    .mem_address(mem_addr), .mem_write_data(mem_wdata),
    .mem_read_not_write(mem_rnw), .mem_cs(mem_cs),
    .mem_read_data(mem_rdata), .busy(busy)
  );

  assign mem_rdata = ram[mem_addr];
  always @(posedge clk) begin
    if (mem_cs && !mem_rnw) ram[mem_addr] <= mem_wdata;
  end

  // instance b: MEM_LATENCY=3, RAM word = addr + 0x100000
  logic        b_req0, b_ack0, b_ack1, b_rnw, b_cs, b_busy;
  logic [10:0] b_addr0, b_maddr;
  logic [23:0] b_rdata, b_wdata, b_mrdata;
  logic        b_zero1 = 1'b0;
  logic [10:0] b_zaddr = '0;
  logic [23:0] b_zdata = '0;

  dram_port_arbiter #(
    .DATA_BUS_WIDTH(24), .ADDRESS_BUS_WIDTH(11), .MEM_LATENCY(3)
  ) u_b (
    .clk(clk), .reset(reset),
    .req0(b_req0), .req1(b_zero1), .rnw0(1'b1), .rnw1(b_zero1),
    .addr0(b_addr0), .addr1(b_zaddr), .wdata0(b_zdata), .wdata1(b_zdata),
    .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata),
    .mem_address(b_maddr), .mem_write_data(b_wdata),
    .mem_read_not_write(b_rnw), .mem_cs(b_cs),
    .mem_read_data(b_mrdata), .busy(b_busy)
  );

  assign b_mrdata = {13'd0, b_maddr} + 24'h100000;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int exp_port [4];

  initial begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
    exp_port = '{0, 0, 0, 0};
`else
    exp_port = '{1, 0, 1, 0};
`endif
    for (int i = 0; i < 2048; i++) ram[i] = 24'(i * 3);
    ram[5] = 24'h00ABCD;
    req0 = 0; req1 = 0; rnw0 = 1; rnw1 = 1;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    b_req0 = 0; b_addr0 = 0;

    // reset state
    tick(); tick();
    chk("rst_cs", 32'(mem_cs), 0);
    chk("rst_rnw", 32'(mem_rnw), 1);
    reset = 1'b1;
    tick();
    chk("idle_ack", {ack0, ack1}, 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_rnw", 32'(mem_rnw), 1);
    chk("idle_addr", 32'(mem_addr), 0);
    chk("idle_rdata", 32'(rdata), 0);
    chk("idle_wdata", 32'(mem_wdata), 0);

    // port 0 read addr 5, latency 1
    req0 = 1; rnw0 = 1; addr0 = 11'd5;
    tick();
    chk("rd_cs", 32'(mem_cs), 1);
    chk("rd_addr", 32'(mem_addr), 5);
    chk("rd_busy", 32'(busy), 1);
    chk("rd_noack", {ack0, ack1}, 0);
    addr0 = 11'd7;
    tick();
    chk("rd_cs_off", 32'(mem_cs), 0);
    chk("rd_ack", {ack0, ack1}, 2'b10);
    chk("rd_data", 32'(rdata), 32'h00ABCD);
    chk("rd_resp_busy", 32'(busy), 1);
    req0 = 0;
    tick();
    chk("rd_ack_pulse", {ack0, ack1}, 0);
    chk("rd_idle_busy", 32'(busy), 0);
    chk("rd_hold_addr", 32'(mem_addr), 5);

    // port 1 write, req dropped mid-transaction
    req1 = 1; rnw1 = 0; addr1 = 11'd1023; wdata1 = 24'h123456;
    tick();
    chk("wr_cs", 32'(mem_cs), 1);
    chk("wr_rnw", 32'(mem_rnw), 0);
    chk("wr_addr", 32'(mem_addr), 1023);
    chk("wr_wdata", 32'(mem_wdata), 32'h123456);
    req1 = 0;
    tick();
    chk("wr_ack", {ack0, ack1}, 2'b01);
    chk("wr_rdata_hold", 32'(rdata), 32'h00ABCD);
    tick();
    chk("wr_rnw_back", 32'(mem_rnw), 1);
    chk("wr_ram", 32'(ram[1023]), 32'h123456);

    // re-read via port 0
    req0 = 1; rnw0 = 1; addr0 = 11'd1023;
    tick();
    tick();
    chk("rerd_ack", {ack0, ack1}, 2'b10);
    chk("rerd_data", 32'(rdata), 32'h123456);
    req0 = 0;
    tick();

    // both requesting continuously
    req0 = 1; rnw0 = 1; addr0 = 11'd5;
    req1 = 1; rnw1 = 1; addr1 = 11'd1023;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("arb_cs", 32'(mem_cs), 1);
      chk("arb_addr", 32'(mem_addr), exp_port[i] == 1 ? 1023 : 5);
      tick();
      chk("arb_ack", {ack0, ack1}, exp_port[i] == 1 ? 2'b01 : 2'b10);
      chk("arb_data", 32'(rdata),
          exp_port[i] == 1 ? 32'h123456 : 32'h00ABCD);
      tick();
      chk("arb_idle", 32'(busy), 0);
    end
    req0 = 0; req1 = 0;
    tick();
    chk("arb_quiet", 32'(busy), 0);

    // reset during ACCESS
    req0 = 1; rnw0 = 1; addr0 = 11'd5;
    tick();
    chk("ra_cs", 32'(mem_cs), 1);
    reset = 1'b0;
    #1;
    chk("ra_cs_drop", 32'(mem_cs), 0);
    chk("ra_busy", 32'(busy), 0);
    req0 = 0;
    tick();
    chk("ra_noack", {ack0, ack1}, 0);
    reset = 1'b1;
    tick();
    chk("ra_noack2", {ack0, ack1}, 0);
    chk("ra_idle_cs", 32'(mem_cs), 0);
    req1 = 1; rnw1 = 1; addr1 = 11'd5;
    tick();
    chk("ra_next_cs", 32'(mem_cs), 1);
    tick();
    chk("ra_next_ack", {ack0, ack1}, 2'b01);
    chk("ra_next_data", 32'(rdata), 32'h00ABCD);
    req1 = 0;
    tick();

    // latency 3 instance
    b_req0 = 1; b_addr0 = 11'd9;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("l3_cs", 32'(b_cs), 1);
      chk("l3_busy", 32'(b_busy), 1);
      chk("l3_noack", {b_ack0, b_ack1}, 0);
      b_req0 = 0;
    end
    tick();
    chk("l3_cs_off", 32'(b_cs), 0);
    chk("l3_ack", {b_ack0, b_ack1}, 2'b10);
    chk("l3_busy4", 32'(b_busy), 1);
    chk("l3_data", 32'(b_rdata), 32'h100009);
    tick();
    chk("l3_idle", {b_ack0, b_busy}, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
